// File: rtl/tick_timer.sv
// Prescaled up/down tick timer: one tick every CLKS_PER_TICK enabled cycles, with a sticky
// expired flag and either saturating or reloading terminal behaviour.
module tick_timer #(
    parameter int unsigned WIDTH         = 11,
    parameter int unsigned CLKS_PER_TICK = 50000,
    parameter bit          WRAP          = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             restart_i,
    input  logic             enable_i,
    input  logic             up_i,
    input  logic [WIDTH-1:0] start_value_i,
    input  logic [WIDTH-1:0] limit_value_i,
    output logic [WIDTH-1:0] timer_value_o,
    output logic             tick_o,
    output logic             expired_o
);

    localparam int unsigned PsW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam logic [PsW-1:0] PsLast = PsW'(CLKS_PER_TICK - 1);

    logic [PsW-1:0]   ps_q, ps_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic             tick_q, tick_d;
    logic             expired_q, expired_d;

    logic             at_last;
    logic             terminal;
    logic [WIDTH-1:0] stepped;
    logic             stepped_terminal;

    always_comb begin
        at_last          = (ps_q == PsLast);
        terminal         = up_i ? (value_q >= limit_value_i) : (value_q == '0);
        // Only used when not terminal, so the step can never over- or underflow.
        stepped          = up_i ? (value_q + WIDTH'(1)) : (value_q - WIDTH'(1));
        stepped_terminal = up_i ? (stepped >= limit_value_i) : (stepped == '0);

        ps_d      = ps_q;
        value_d   = value_q;
        tick_d    = 1'b0;
        expired_d = expired_q;

        if (restart_i) begin
            ps_d      = '0;
            expired_d = 1'b0;
            value_d   = up_i ? '0 : start_value_i;
        end else if (enable_i) begin
            if (at_last) begin
                ps_d   = '0;
                tick_d = 1'b1;
                if (!terminal) begin
                    value_d   = stepped;
                    expired_d = expired_q | stepped_terminal;
                end else begin
                    expired_d = 1'b1;
                    if (WRAP) begin
                        value_d = up_i ? '0 : start_value_i;
                    end
                end
            end else begin
                ps_d = ps_q + PsW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ps_q      <= '0;
            value_q   <= '0;
            tick_q    <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            ps_q      <= ps_d;
            value_q   <= value_d;
            tick_q    <= tick_d;
            expired_q <= expired_d;
        end
    end

    assign timer_value_o = value_q;
    assign tick_o        = tick_q;
    assign expired_o     = expired_q;

endmodule

// File: tb/tb_tick_timer.sv
// Bench for tick_timer: a saturating and a wrapping instance share stimulus; every tick of the
// selected instance is matched against a queue of expected (edge, value, expired) entries.
module tb_tick_timer;

    localparam int unsigned W   = 11;
    localparam int unsigned CPT = 5;

    typedef struct {
        int cyc;
        int value;
        bit expired;
    } exp_t;

    logic         clk;
    logic         rst_ni;
    logic         restart;
    logic         enable;
    logic         up;
    logic [W-1:0] start_value;
    logic [W-1:0] limit_value;

    logic [W-1:0] val_s, val_w, val_m;
    logic         tick_s, tick_w, tick_m;
    logic         exp_s, exp_w, exp_m;
    logic         sel;

    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t q[$];

    tick_timer #(.WIDTH(W), .CLKS_PER_TICK(CPT), .WRAP(1'b0)) u_sat (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .restart_i     (restart),
        .enable_i      (enable),
        .up_i          (up),
        .start_value_i (start_value),
        .limit_value_i (limit_value),
        .timer_value_o (val_s),
        .tick_o        (tick_s),
        .expired_o     (exp_s)
    );

    tick_timer #(.WIDTH(W), .CLKS_PER_TICK(CPT), .WRAP(1'b1)) u_wrap (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .restart_i     (restart),
        .enable_i      (enable),
        .up_i          (up),
        .start_value_i (start_value),
        .limit_value_i (limit_value),
        .timer_value_o (val_w),
        .tick_o        (tick_w),
        .expired_o     (exp_w)
    );

    assign val_m  = sel ? val_w : val_s;
    assign tick_m = sel ? tick_w : tick_s;
    assign exp_m  = sel ? exp_w : exp_s;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: each observed tick must match the head of the expectation queue.
    always @(negedge clk) begin
        if (tick_m) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_tick: edge=%0d value=%0d expired=%0d, required no tick",
                         cyc, val_m, exp_m);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (e.cyc != cyc || e.value != int'(val_m) || e.expired != exp_m) begin
                    errors++;
                    $display("FAIL tick: edge=%0d value=%0d expired=%0d, required edge=%0d value=%0d expired=%0d",
                             cyc, val_m, exp_m, e.cyc, e.value, e.expired);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int c, input int v, input bit e);
        exp_t x;
        x.cyc = c;
        x.value = v;
        x.expired = e;
        q.push_back(x);
    endtask

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    // Lets the monitor see the current cycle, then flags any expected tick that never came.
    task automatic drain(input string nm);
        @(negedge clk);
        #1;
        chk(nm, q.size(), 0);
        q.delete();
    endtask

    initial begin
        int c;
        int r;
        sel         = 1'b0;
        rst_ni      = 1'b1;
        restart     = 1'b0;
        enable      = 1'b0;
        up          = 1'b1;
        start_value = '0;
        limit_value = 11'd2047;

        #2 rst_ni = 1'b0;
        #1;
        chk("reset_value", val_m, 0);
        chk("reset_tick", tick_m, 0);
        chk("reset_expired", exp_m, 0);
        step(2);

        // Up-count from reset without restart.
        rst_ni = 1'b1;
        enable = 1'b1;
        c = cyc;
        push(c + 5, 1, 0);
        push(c + 10, 2, 0);
        step(10);
        drain("startup_ticks");

        // Restart then 15 cycles of up-count.
        restart = 1'b1;
        r = cyc + 1;
        step(1);
        restart = 1'b0;
        chk("up_restart_value", val_m, 0);
        push(r + 5, 1, 0);
        push(r + 10, 2, 0);
        push(r + 15, 3, 0);
        step(15);
        drain("up_ticks");
        chk("up_value", val_m, 3);
        chk("up_expired", exp_m, 0);

        // Down-count with a pause.
        start_value = 11'd7;
        up = 1'b0;
        restart = 1'b1;
        r = cyc + 1;
        step(1);
        restart = 1'b0;
        chk("down_reload", val_m, 7);
        push(r + 5, 6, 0);
        push(r + 10, 5, 0);
        step(10);
        chk("down_after10", val_m, 5);
        enable = 1'b0;
        step(20);
        chk("paused_value", val_m, 5);
        enable = 1'b1;
        c = cyc;
        push(c + 5, 4, 0);
        step(5);
        drain("down_resume");
        chk("down_resumed", val_m, 4);

        // Partial tick survives a pause.
        step(3);
        enable = 1'b0;
        step(8);
        enable = 1'b1;
        c = cyc;
        push(c + 2, 3, 0);
        step(2);
        drain("partial_tick");

        // Saturation at 0 going down, then up to limit 3 and hold.
        start_value = 11'd2;
        restart = 1'b1;
        r = cyc + 1;
        step(1);
        restart = 1'b0;
        push(r + 5, 1, 0);
        push(r + 10, 0, 1);
        push(r + 15, 0, 1);
        push(r + 20, 0, 1);
        push(r + 25, 0, 1);
        step(25);
        up = 1'b1;
        limit_value = 11'd3;
        push(r + 30, 1, 1);
        push(r + 35, 2, 1);
        push(r + 40, 3, 1);
        push(r + 45, 3, 1);
        step(20);
        drain("saturate");
        chk("sat_value", val_m, 3);
        chk("sat_expired", exp_m, 1);

        // Wrapping instance: 1,2,3,0,1 with expired sticky across the wrap.
        sel = 1'b1;
        restart = 1'b1;
        r = cyc + 1;
        step(1);
        restart = 1'b0;
        push(r + 5, 1, 0);
        push(r + 10, 2, 0);
        push(r + 15, 3, 1);
        push(r + 20, 0, 1);
        push(r + 25, 1, 1);
        step(25);
        drain("wrap_seq");
        chk("wrap_expired", exp_m, 1);
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        chk("wrap_restart_expired", exp_m, 0);
        chk("wrap_restart_value", val_m, 0);

        // Async reset between edges discards progress.
        limit_value = 11'd1;
        r = cyc;
        push(r + 5, 1, 1);
        step(7);
        drain("pre_reset_tick");
        rst_ni = 1'b0;
        #1;
        chk("async_value", val_m, 0);
        chk("async_tick", tick_m, 0);
        chk("async_expired", exp_m, 0);
        enable = 1'b0;
        rst_ni = 1'b1;

        // Restart held with enable: value pinned at reload and no ticks.
        up = 1'b0;
        start_value = 11'd9;
        restart = 1'b1;
        enable = 1'b1;
        step(12);
        chk("pinned_value", val_m, 9);
        chk("pinned_tick", tick_m, 0);
        restart = 1'b0;
        c = cyc;
        push(c + 5, 8, 0);
        step(5);
        drain("post_restart_tick");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tick_timer.md
TICK_TIMER -- requirements
Module: tick_timer

Interface
REQ-001 SHALL have parameter WIDTH, default 11, timer value width in bits (>=2).
REQ-002 SHALL have parameter CLKS_PER_TICK, default 50000, clk cycles per timer tick (>=1; 50000 = 1 ms at 50 MHz).
REQ-003 SHALL have parameter WRAP, default 0, terminal behaviour (0 = saturate, 1 = wrap/reload).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port restart  input  1  synchronous reload of the count in the current direction.
REQ-007 SHALL have port enable  input  1  1 = run, 0 = pause.
REQ-008 SHALL have port up  input  1  count direction (1 = up, 0 = down).
REQ-009 SHALL have port start_value  input  WIDTH  down-count reload value.
REQ-010 SHALL have port limit_value  input  WIDTH  up-count terminal value.
REQ-011 SHALL have port timer_value  output  WIDTH  current count, registered.
REQ-012 SHALL have port tick  output  1  one-cycle pulse on each counted tick, registered.
REQ-013 SHALL have port expired  output  1  sticky terminal-reached flag, registered.

Function
REQ-014 SHALL hold a prescaler of $clog2(CLKS_PER_TICK) bits (min 1) counting 0..CLKS_PER_TICK-1.
REQ-015 SHALL advance the prescaler by 1 per clk edge only when enable=1 and restart=0.
REQ-016 SHALL, on an edge where the prescaler is CLKS_PER_TICK-1 and it advances, clear the prescaler, assert tick for exactly that next cycle and update timer_value on the same edge.
REQ-017 SHALL, with CLKS_PER_TICK=1, tick on every enabled edge.
REQ-018 SHALL, with enable=0, hold prescaler, timer_value and expired; a partially elapsed tick resumes where it stopped, with no loss or extra tick.
REQ-019 SHALL give restart priority over enable: prescaler <= 0, tick <= 0, expired <= 0, timer_value <= 0 if up=1, else start_value.
REQ-020 SHALL define terminal as timer_value >= limit_value when up=1, and timer_value == 0 when up=0.
REQ-021 SHALL, on a tick from a non-terminal value, step timer_value by +1 (up) or -1 (down), and set expired if the new value is terminal.
REQ-022 SHALL, on a tick from a terminal value with WRAP=0, hold timer_value and set expired.
REQ-023 SHALL, on a tick from a terminal value with WRAP=1, load 0 (up) or start_value (down) and keep expired set.
REQ-024 SHALL never let timer_value underflow below 0 or exceed 2^WIDTH-1; all arithmetic is modulo-free, governed by REQ-020..023.
REQ-025 SHALL apply a change of up mid-run from the next tick, using the current timer_value without reload.
REQ-026 SHALL sample start_value and limit_value combinationally at the edge where they are used; changes need no restart.
REQ-027 SHALL clear expired only via restart or reset.

Reset
REQ-028 SHALL, while reset=0, force asynchronously (no clock needed): timer_value=0, prescaler=0, tick=0, expired=0.
REQ-029 SHALL begin prescaling on the first rising edge after reset returns to 1 if enable=1; restart is not required to start up-counting from 0.
REQ-030 SHALL, if reset is asserted mid-tick or mid-restart, discard all partial progress.

Verification (CLKS_PER_TICK=5, WIDTH=11 unless stated)
REQ-031 Up count: limit=2047, up=1, enable=1, 1-cycle restart, then 15 cycles -> timer_value=3, tick pulsed 3 times exactly 5 cycles apart, expired=0.
REQ-032 Down count with pause: start=7, up=0, restart -> timer_value=7 after the edge; 10 cycles -> 5; enable=0 for 20 cycles -> still 5, no tick; enable=1 for 5 cycles -> 4.
REQ-033 Partial tick: enable=1 for 3 cycles, enable=0 for 8 cycles, enable=1 -> next tick exactly 2 enabled cycles later.
REQ-034 Saturate (WRAP=0): start=2, up=0, restart, 25 cycles -> timer_value=0 after 10 cycles, expired=1 from that edge, value stays 0 with tick still pulsing; up=1, limit=3 from 0 -> 3, held.
REQ-035 Wrap (WRAP=1): up=1, limit=3, from 0 -> sequence 1,2,3,0,1 on successive ticks, expired set at 3 and still 1 after wrap; restart clears it.
REQ-036 Async reset/priority: drop reset mid-prescale between edges -> all outputs 0 before the next edge; restart=1 with enable=1 held -> value pinned at reload, no tick.
